// File: rtl/mem_port_arbiter_if.sv
// Signal bundle between the RV64 pipeline (fetch and load/store paths), the
// memory port arbiter and the shared 64-bit memory bus.
interface mem_port_arbiter_if #(
   parameter int ADDR_W = 64,
   parameter int DATA_W = 64
);

   logic              if_req;
   logic [ADDR_W-1:0] if_addr;
   logic              if_flush;
   logic              if_valid;
   logic [31:0]       if_inst;
   logic              if_stall;

   logic              d_req;
   logic              d_we;
   logic [ADDR_W-1:0] d_addr;
   logic [DATA_W-1:0] d_wdata;
   logic [7:0]        d_wstrb;
   logic              d_valid;
   logic [DATA_W-1:0] d_rdata;
   logic              d_stall;

   logic              bus_req;
   logic              bus_we;
   logic [ADDR_W-1:0] bus_addr;
   logic [DATA_W-1:0] bus_wdata;
   logic [7:0]        bus_wstrb;
   logic              bus_ready;
   logic [DATA_W-1:0] bus_rdata;

   // The arbiter is the bus master; the pipeline and memory sit on the slave side
   modport master (
      input  if_req, if_addr, if_flush,
      output if_valid, if_inst, if_stall,
      input  d_req, d_we, d_addr, d_wdata, d_wstrb,
      output d_valid, d_rdata, d_stall,
      output bus_req, bus_we, bus_addr, bus_wdata, bus_wstrb,
      input  bus_ready, bus_rdata
   );

   modport slave (
      output if_req, if_addr, if_flush,
      input  if_valid, if_inst, if_stall,
      output d_req, d_we, d_addr, d_wdata, d_wstrb,
      input  d_valid, d_rdata, d_stall,
      input  bus_req, bus_we, bus_addr, bus_wdata, bus_wstrb,
      output bus_ready, bus_rdata
   );

endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one 64-bit memory bus between instruction fetch
// and load/store, with stall generation and discard of flushed fetches.
module mem_port_arbiter #(
   parameter int ADDR_W = 64,
   parameter int DATA_W = 64
) (
   input logic             clk,
   input logic             rst,
   mem_port_arbiter_if.master port
);

   typedef enum logic [1:0] {IDLE, IF_BUSY, D_BUSY} state_t;
   typedef enum logic {GRANT_IF, GRANT_D} grant_t;

   state_t            state_q, state_d;
   grant_t            lastGrant_q, lastGrant_d;
   logic              drop_q, drop_d;
   logic              ifHalf_q, ifHalf_d;
   logic              busReq_q, busReq_d;
   logic              busWe_q, busWe_d;
   logic [ADDR_W-1:0] busAddr_q, busAddr_d;
   logic [DATA_W-1:0] busWdata_q, busWdata_d;
   logic [7:0]        busWstrb_q, busWstrb_d;

   logic fetchOk;
   logic grantIf;
   logic grantD;
   logic ifValid;
   logic dValid;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         lastGrant_q <= GRANT_IF;
         drop_q      <= 1'b0;
         ifHalf_q    <= 1'b0;
         busReq_q    <= 1'b0;
         busWe_q     <= 1'b0;
         busAddr_q   <= '0;
         busWdata_q  <= '0;
         busWstrb_q  <= '0;
      end else begin
         state_q     <= state_d;
         lastGrant_q <= lastGrant_d;
         drop_q      <= drop_d;
         ifHalf_q    <= ifHalf_d;
         busReq_q    <= busReq_d;
         busWe_q     <= busWe_d;
         busAddr_q   <= busAddr_d;
         busWdata_q  <= busWdata_d;
         busWstrb_q  <= busWstrb_d;
      end
   end

   // A grant can only happen from IDLE, so back-to-back transactions always
   // see one idle cycle; a flushed fetch is never granted in its flush cycle.
   always_comb begin
      state_d     = state_q;
      lastGrant_d = lastGrant_q;
      drop_d      = drop_q;
      ifHalf_d    = ifHalf_q;
      busReq_d    = busReq_q;
      busWe_d     = busWe_q;
      busAddr_d   = busAddr_q;
      busWdata_d  = busWdata_q;
      busWstrb_d  = busWstrb_q;
      fetchOk     = port.if_req & ~port.if_flush;
      grantIf     = 1'b0;
      grantD      = 1'b0;

      case (state_q)
         IDLE: begin
            if (fetchOk && port.d_req) begin
               grantD  = (lastGrant_q == GRANT_IF);
               grantIf = (lastGrant_q == GRANT_D);
            end else begin
               grantIf = fetchOk;
               grantD  = port.d_req;
            end

            if (grantIf) begin
               state_d     = IF_BUSY;
               lastGrant_d = GRANT_IF;
               busReq_d    = 1'b1;
               busWe_d     = 1'b0;
               busAddr_d   = port.if_addr;
               busWdata_d  = '0;
               busWstrb_d  = '0;
               ifHalf_d    = port.if_addr[2];
            end else if (grantD) begin
               state_d     = D_BUSY;
               lastGrant_d = GRANT_D;
               busReq_d    = 1'b1;
               busWe_d     = port.d_we;
               busAddr_d   = port.d_addr;
               busWdata_d  = port.d_wdata;
               busWstrb_d  = port.d_we ? port.d_wstrb : 8'h00;
            end
         end

         // The bus cannot abort, so a flush only marks the fetch for discard
         IF_BUSY: begin
            if (port.bus_ready) begin
               state_d  = IDLE;
               busReq_d = 1'b0;
               drop_d   = 1'b0;
            end else if (port.if_flush) begin
               drop_d = 1'b1;
            end
         end

         D_BUSY: begin
            if (port.bus_ready) begin
               state_d  = IDLE;
               busReq_d = 1'b0;
            end
         end

         default: begin
            state_d  = IDLE;
            busReq_d = 1'b0;
            drop_d   = 1'b0;
         end
      endcase
   end

   always_comb begin
      ifValid = (state_q == IF_BUSY) & port.bus_ready & ~drop_q & ~port.if_flush;
      dValid  = (state_q == D_BUSY) & port.bus_ready;

      port.if_valid  = ifValid;
      port.if_inst   = ifHalf_q ? port.bus_rdata[63:32] : port.bus_rdata[31:0];
      port.if_stall  = port.if_req & ~ifValid;
      port.d_valid   = dValid;
      port.d_rdata   = port.bus_rdata;
      port.d_stall   = port.d_req & ~dValid;

      port.bus_req   = busReq_q;
      port.bus_we    = busWe_q;
      port.bus_addr  = busAddr_q;
      port.bus_wdata = busWdata_q;
      port.bus_wstrb = busWstrb_q;
   end

endmodule
